// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter (IDLE/GRANT FSM, registered one-hot grant).
// Optional hold-time limit: define RR_ARBITER8_TIMEOUT_EN. Revision 1.0
`default_nettype none

module rr_arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter8: HOLD_MAX must be within 2..255");
  end

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic [7:0] gnt_nxt;
  logic       valid_nxt;
  logic [2:0] pick;
  logic       found;
  logic       timeout;
  logic       release_gnt;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    logic [2:0] cand;
    cand  = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;

  // Only preempt the owner when someone else is actually waiting.
  assign timeout = (hold_cnt == HOLD_LIM) && ((req & ~gnt) != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE) begin
      hold_cnt <= 8'd0;
    end else if (hold_cnt != HOLD_LIM) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign release_gnt = done | ~req[gnt_idx] | timeout;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    gnt_nxt   = gnt;
    valid_nxt = gnt_valid;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nxt   = pick;
          gnt_nxt   = 8'd1 << pick;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end else begin
          gnt_nxt   = 8'h00;
          valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          gnt_nxt   = 8'h00;
          valid_nxt = 1'b0;
          ptr_nxt   = gnt_idx + 3'd1;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = 8'h00;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_idx   <= 3'd0;
      gnt       <= 8'h00;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= idx_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8 -- directed and random checks of rr_arbiter8 against a behavioural model.
`default_nettype none

module tb_rr_arbiter8;
  localparam int HM = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       done  = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  rr_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner is -1 when nobody holds the resource.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_last  = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_last  = m_owner;
          m_hold  = 0;
        end
      end
    end else begin
      bit rel;
      rel = done || !req[m_owner];
`ifdef RR_ARBITER8_TIMEOUT_EN
      if (m_hold == HM - 1 && (req & ~(8'd1 << m_owner)) != 8'h00) rel = 1'b1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (m_hold < HM - 1) begin
        m_hold = m_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", gnt, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("gnt_idx", gnt_idx, m_last);
      check("gnt_valid", gnt_valid, m_owner >= 0);
      check("onehot0", $onehot0(gnt), 1);
      check("decode", gnt, gnt_valid ? (32'd1 << gnt_idx) : 32'd0);
    end
  end

  task automatic step(input logic [7:0] r, input logic d);
    @(negedge clk);
    #2;
    req  = r;
    done = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int nxt;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_gnt", gnt, 0);
    check("reset_valid", gnt_valid, 0);
    #2 rst_n = 1'b1;

    // Single requester, release by done.
    step(8'h01, 1'b0);
    @(negedge clk);
    check("r26_gnt", gnt, 8'h01);
    check("r26_valid", gnt_valid, 1);
    #2 done = 1'b1;
    @(negedge clk);
    check("r26_release", gnt, 8'h00);
    #2 done = 1'b0;

    // All requesting, released every grant cycle: strict rotation with idle gaps.
    do_reset();
    req  = 8'hFF;
    done = 1'b1;
    nxt  = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("r27_gap", gnt_valid, (c % 2) == 0);
      if (gnt_valid) begin
        check("r27_order", gnt_idx, nxt % 8);
        nxt++;
      end
    end
    check("r27_count", nxt, 9);

    // Pointer after granting 5 is 6: search 6,7,0 then 1..5.
    do_reset();
    step(8'h20, 1'b0);
    step(8'h20, 1'b1);
    step(8'h21, 1'b0);
    @(negedge clk);
    check("r28_first", gnt, 8'h01);
    #2 done = 1'b1;
    step(8'h21, 1'b0);
    @(negedge clk);
    check("r28_second", gnt, 8'h20);

    // Asynchronous reset drops an active grant without a clock edge.
    do_reset();
    step(8'h10, 1'b0);
    @(negedge clk);
    check("r29_pre", gnt, 8'h10);
    #2 rst_n = 1'b0;
    req = 8'hFF;
    #1;
    check("r29_async_gnt", gnt, 8'h00);
    check("r29_async_valid", gnt_valid, 0);
    check("r29_async_idx", gnt_idx, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("r29_first", gnt, 8'h01);

`ifdef RR_ARBITER8_TIMEOUT_EN
    begin
      int exp_idx [6] = '{0, 0, 0, 0, -1, 1};
      do_reset();
      step(8'h03, 1'b0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check("r30_seq", gnt_valid ? int'(gnt_idx) : -1, exp_idx[c]);
      end
      do_reset();
      step(8'h01, 1'b0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        check("r30_hold", gnt, 8'h01);
      end
    end
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      case ($urandom_range(0, 3))
        0: req = 8'h00;
        1: req = 8'd1 << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      done  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
